mux_nto1_scan: RTL and testbench

Registered, parametrised N-channel, W-bit selector; successor to the fixed 5-to-1 3-bit lab multiplexers. Two modes: manual, where `sel` picks the channel as before, and auto-scan, where the block steps through every channel and dwells a programmable number of cycles on each. Intended to feed the board display/LED stage so all inputs can be inspected without touching the switches. Out-of-range selects are flagged, not aliased.

---
 rtl/mux_scan_pkg.sv | 7 +
 rtl/mux_nto1.sv | 16 +
 rtl/mux_nto1_scan.sv | 74 +++++++
 tb/tb_mux_nto1_scan.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: scan-mux state encoding and select-width helper
package mux_scan_pkg;
    typedef enum logic [1:0] {S_MAN, S_SCAN, S_HOLD} state_t;
    function automatic int sw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mux_nto1.sv
// mux_nto1: combinational WIDTH x NCH selector, out-of-range select yields zero
module mux_nto1 #(
    parameter int WIDTH = 3,
    parameter int NCH   = 5,
    parameter int SW    = 3
) (
    input  logic [NCH*WIDTH-1:0] i_din,
    input  logic [SW-1:0]        i_sel,
    output logic [WIDTH-1:0]     o_dout
);
    always_comb begin
        o_dout = '0;
        for (int i = 0; i < NCH; i++)
            if (i_sel == SW'(i)) o_dout = i_din[i*WIDTH +: WIDTH];
    end
endmodule

// File: rtl/mux_nto1_scan.sv
// mux_nto1_scan: registered N-channel selector with manual select and dwell-timed auto-scan
module mux_nto1_scan
    import mux_scan_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int NCH   = 5,
    parameter int DWELL = 4,
    parameter int SW    = sw_of(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [SW-1:0]        sel,
    input  logic                 mode,
    input  logic                 hold,
    output logic [WIDTH-1:0]     dout,
    output logic [SW-1:0]        cur_ch,
    output logic                 ch_step,
    output logic                 sel_err
);
    localparam int CW = sw_of(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
    localparam logic [SW-1:0] TOP  = SW'(NCH - 1);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [SW-1:0]    r_cur, w_cur_nxt;
    logic [WIDTH-1:0] r_dout, w_mux;
    logic             r_step, r_err, w_err_nxt, w_sel_ok, w_man, w_adv;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_MAN;
        else        r_state <= w_state_nxt;

    always_comb
        w_state_nxt = !mode ? S_MAN : (r_state == S_MAN) ? S_SCAN : hold ? S_HOLD : S_SCAN;

    // Manual behaviour applies both in S_MAN and on the edge that leaves scan via mode=0.
    always_comb begin
        w_sel_ok  = 32'(sel) < NCH;
        w_man     = !mode || r_state == S_MAN;
        w_adv     = !w_man && !hold && r_cnt == LAST;
        w_cnt_nxt = (w_man || w_adv) ? '0 : hold ? r_cnt : r_cnt + 1'b1;
        w_cur_nxt = w_man ? (w_sel_ok ? sel : mode ? '0 : r_cur)
                  : w_adv ? ((r_cur == TOP) ? '0 : r_cur + 1'b1) : r_cur;
        w_err_nxt = !mode && !w_sel_ok;
    end

    mux_nto1 #(.WIDTH(WIDTH), .NCH(NCH), .SW(SW)) u_mux (
        .i_din (din),
        .i_sel (w_cur_nxt),
        .o_dout(w_mux)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_cnt  <= '0;
            r_cur  <= '0;
            r_dout <= '0;
            r_step <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_cur  <= w_cur_nxt;
            r_dout <= w_err_nxt ? '0 : w_mux;
            r_step <= w_cur_nxt != r_cur;
            r_err  <= w_err_nxt;
        end

    assign dout    = r_dout;
    assign cur_ch  = r_cur;
    assign ch_step = r_step;
    assign sel_err = r_err;
endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb_mux_nto1_scan: directed and random checks of the scan mux against a behavioural model
module tb_mux_nto1_scan;
    localparam int W = 3, N = 5, D = 4;

    logic        clk = 1'b0, rst_n = 1'b0, mode = 1'b0, hold = 1'b0;
    logic [14:0] din = 15'b101_100_011_010_001;
    logic [2:0]  sel = '0;
    logic [2:0]  dout, cur_ch;
    logic        ch_step, sel_err;

    int n_chk = 0, n_fail = 0;
    int m_cur = 0, m_cnt = 0;
    bit m_scan = 0, m_err = 0, m_step = 0;
    int m_dout = 0;

    mux_nto1_scan dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .hold(hold),
        .dout(dout), .cur_ch(cur_ch), .ch_step(ch_step), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_cnt = 0; m_scan = 0; m_err = 0; m_step = 0; m_dout = 0;
    endtask

    // Behavioural view: manual follows sel; scan spends D unheld edges per channel.
    task automatic model_edge();
        int prev = m_cur;
        if (!mode) begin
            m_scan = 0;
            m_cnt  = 0;
            m_err  = (sel >= N);
            if (!m_err) m_cur = sel;
        end else if (!m_scan) begin
            m_scan = 1;
            m_cnt  = 0;
            m_err  = 0;
            m_cur  = (sel < N) ? int'(sel) : 0;
        end else begin
            m_err = 0;
            if (!hold) begin
                m_cnt++;
                if (m_cnt == D) begin
                    m_cnt = 0;
                    m_cur = (m_cur + 1) % N;
                end
            end
        end
        m_dout = m_err ? 0 : int'((din >> (m_cur * W)) & 15'd7);
        m_step = (m_cur != prev);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, int'(dout), m_dout);
        chk({tag, ".cur_ch"}, int'(cur_ch), m_cur);
        chk({tag, ".ch_step"}, int'(ch_step), int'(m_step));
        chk({tag, ".sel_err"}, int'(sel_err), int'(m_err));
    endtask

    task automatic tick(input logic m, input logic [2:0] s, input logic h, input string tag);
        mode = m; sel = s; hold = h;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        #1 rst_n = 1'b1;

        tick(0, 3'd2, 0, "man_sel2");
        chk("man_sel2.dout_const", int'(dout), 3);
        tick(0, 3'd2, 0, "man_sel2_again");
        tick(0, 3'd6, 0, "man_sel6");
        chk("man_sel6.err_const", int'(sel_err), 1);
        tick(0, 3'd4, 0, "man_sel4");
        chk("man_sel4.dout_const", int'(dout), 5);

        tick(1, 3'd3, 0, "scan_entry");
        chk("scan_entry.cur_const", int'(cur_ch), 3);
        for (int i = 0; i < 24; i++) tick(1, 3'd3, 0, "scan_run");

        tick(0, 3'd1, 0, "to_man1");
        tick(1, 3'd1, 0, "scan_ch1");
        tick(1, 3'd1, 0, "scan_ch1_dw2");
        for (int i = 0; i < 10; i++) begin
            if (i == 5) din[5:3] = 3'd7;
            tick(1, 3'd1, 1, "hold");
        end
        chk("hold.dout_const", int'(dout), 7);
        tick(1, 3'd1, 0, "release1");
        chk("release1.cur_const", int'(cur_ch), 1);
        tick(1, 3'd1, 0, "release2");
        tick(1, 3'd1, 0, "release3");
        chk("release3.cur_const", int'(cur_ch), 2);
        din = 15'b101_100_011_010_001;

        for (int i = 0; i < 6; i++) tick(1, 3'd0, 0, "scan_pre");
        tick(0, 3'd0, 1, "mode_beats_hold");
        chk("mode_beats_hold.dout_const", int'(dout), 1);

        for (int i = 0; i < 7; i++) tick(1, 3'd2, 0, "scan_pre_rst");
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk) rst_n = 1'b1;
        tick(1, 3'd4, 0, "post_reset_entry");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) din = 15'($urandom);
            tick(logic'($urandom_range(0, 9) != 0), 3'($urandom), logic'($urandom_range(0, 4) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
